// File: rtl/vram_arb_responder.sv
// Frame-buffer responder: in-order request queue in front of a single-port byte-lane RAM.
// Reads return on out_data with a one-cycle out_xfc strobe.
module vram_arb_responder #(
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned LOG2QDEPTH = 2,
  parameter int unsigned MEM_AW     = 14
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic [31:0] in_data,
  input  logic [15:0] in_addr,
  input  logic [3:0]  in_wben,
  input  logic        in_op,
  input  logic        in_rts,
  output logic        out_rtr,
  output logic [31:0] out_data,
  output logic        out_xfc,
  input  logic        mem_busy,
  output logic        idle
);

  localparam logic [LOG2QDEPTH:0] CntFull = (LOG2QDEPTH + 1)'(QDEPTH);

  logic [31:0]         q_data [QDEPTH];
  logic [MEM_AW-1:0]   q_addr [QDEPTH];
  logic [3:0]          q_wben [QDEPTH];
  logic                q_op   [QDEPTH];

  logic [31:0]         mem [2**MEM_AW];

  logic [LOG2QDEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG2QDEPTH:0]   count_q;
  logic                  rdy_q;

  logic                  push, pop, pop_read;
  logic [MEM_AW-1:0]     head_addr;
  logic [31:0]           head_data;
  logic [3:0]            head_wben;

  // rdy_q keeps out_rtr low through reset and until the first edge after release.
  assign out_rtr   = rdy_q && (count_q != CntFull);
  assign push      = in_rts && out_rtr;
  assign pop       = (count_q != '0) && !mem_busy;
  assign head_addr = q_addr[rd_ptr_q];
  assign head_data = q_data[rd_ptr_q];
  assign head_wben = q_wben[rd_ptr_q];
  assign pop_read  = pop && !q_op[rd_ptr_q];
  assign idle      = (count_q == '0) && !out_xfc;

  // Queue storage and RAM carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr_q] <= in_data;
      q_addr[wr_ptr_q] <= in_addr[MEM_AW-1:0];
      q_wben[wr_ptr_q] <= in_wben;
      q_op[wr_ptr_q]   <= in_op;
    end
    if (pop && q_op[rd_ptr_q]) begin
      for (int i = 0; i < 4; i++) begin
        if (head_wben[i]) mem[head_addr][8*i +: 8] <= head_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
      out_data <= '0;
      out_xfc  <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      out_xfc <= pop_read;
      if (pop_read) out_data <= mem[head_addr];
      if (push) wr_ptr_q <= wr_ptr_q + LOG2QDEPTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + LOG2QDEPTH'(1);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arb_responder.sv
// Bench for vram_arb_responder: directed requests, read expectations queued in a scoreboard
// and checked by an independent monitor whenever out_xfc strobes.
module tb_vram_arb_responder;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic [31:0] in_data = '0;
  logic [15:0] in_addr = '0;
  logic [3:0]  in_wben = '0;
  logic        in_op = 1'b0;
  logic        in_rts = 1'b0;
  logic        out_rtr;
  logic [31:0] out_data;
  logic        out_xfc;
  logic        mem_busy = 1'b0;
  logic        idle;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb [$];
  logic [31:0] model [int];

  vram_arb_responder #(.QDEPTH(4), .LOG2QDEPTH(2), .MEM_AW(14)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .in_data  (in_data),
    .in_addr  (in_addr),
    .in_wben  (in_wben),
    .in_op    (in_op),
    .in_rts   (in_rts),
    .out_rtr  (out_rtr),
    .out_data (out_data),
    .out_xfc  (out_xfc),
    .mem_busy (mem_busy),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding read expectation.
  always @(negedge clk) begin
    if (out_xfc) begin
      if (!rst_ || sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_xfc: got out_xfc=1 data=%h, want no strobe", out_data);
      end else begin
        check("read_data", out_data, sb.pop_front());
      end
    end
  end

  // Issue one request; called and returns #1 after a rising edge. track=0 leaves the
  // model and scoreboard untouched (requests that reset will drop).
  task automatic issue(input logic op, input logic [15:0] addr, input logic [31:0] data,
                       input logic [3:0] wben, input logic track);
    int budget = 200;
    int a;
    logic [31:0] w;
    in_rts  = 1'b1;
    in_op   = op;
    in_addr = addr;
    in_data = data;
    in_wben = wben;
    while (!out_rtr && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got out_rtr=0 for 200 cycles, want acceptance");
    end
    a = int'(addr[13:0]);
    if (track) begin
      if (op) begin
        w = model.exists(a) ? model[a] : 32'h0;
        for (int i = 0; i < 4; i++) if (wben[i]) w[8*i +: 8] = data[8*i +: 8];
        model[a] = w;
      end else begin
        sb.push_back(model.exists(a) ? model[a] : 32'h0);
      end
    end
    @(posedge clk); #1;
    in_rts = 1'b0;
  endtask

  initial begin
    // Reset and release.
    #2 rst_ = 1'b0;
    #1;
    check("rtr_in_reset", 32'(out_rtr), 32'd0);
    check("idle_in_reset", 32'(idle), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b1;
    @(posedge clk); #1;
    check("rtr_after_reset", 32'(out_rtr), 32'd1);
    check("idle_after_reset", 32'(idle), 32'd1);
    check("xfc_after_reset", 32'(out_xfc), 32'd0);
    check("data_after_reset", out_data, 32'h0);

    // Full write then read, with strobe timing relative to read acceptance.
    issue(1'b1, 16'h0010, 32'hAABBCCDD, 4'hF, 1'b1);
    check("idle_after_accept", 32'(idle), 32'd0);
    issue(1'b0, 16'h0010, 32'h0, 4'h0, 1'b1);
    check("xfc_lat_e1", 32'(out_xfc), 32'd0);
    @(posedge clk); #1;
    check("xfc_lat_e2", 32'(out_xfc), 32'd1);
    check("data_lat_e2", out_data, 32'hAABBCCDD);
    @(posedge clk); #1;
    check("xfc_one_cycle", 32'(out_xfc), 32'd0);
    check("data_hold", out_data, 32'hAABBCCDD);

    // Partial-lane write, then a zero-wben write, each followed by a read.
    issue(1'b1, 16'h0010, 32'h11223344, 4'b0101, 1'b1);
    issue(1'b0, 16'h0010, 32'h0, 4'hF, 1'b1);
    issue(1'b1, 16'h0010, 32'hFFFFFFFF, 4'b0000, 1'b1);
    issue(1'b0, 16'h0010, 32'h0, 4'h0, 1'b1);
    repeat (4) @(posedge clk); #1;
    check("partial_model", model[16], 32'hAA22CC44);

    // Fill the queue under mem_busy; the fifth request must wait.
    mem_busy = 1'b1;
    issue(1'b1, 16'h0020, 32'hCAFEF00D, 4'hF, 1'b1);
    issue(1'b1, 16'h0021, 32'h0F0F0F0F, 4'hF, 1'b1);
    issue(1'b0, 16'h0020, 32'h0, 4'h0, 1'b1);
    issue(1'b0, 16'h0021, 32'h0, 4'h0, 1'b1);
    check("rtr_full", 32'(out_rtr), 32'd0);
    in_rts = 1'b1; in_op = 1'b0; in_addr = 16'h0010; in_wben = 4'h0;
    repeat (3) @(posedge clk); #1;
    check("rtr_still_full", 32'(out_rtr), 32'd0);
    check("no_xfc_busy", 32'(out_xfc), 32'd0);
    mem_busy = 1'b0;
    @(posedge clk); #1;
    check("rtr_after_pop", 32'(out_rtr), 32'd1);
    sb.push_back(32'hAA22CC44);
    @(posedge clk); #1;
    in_rts = 1'b0;
    repeat (8) @(posedge clk); #1;

    // Address aliasing above MEM_AW.
    issue(1'b1, 16'h4010, 32'h12345678, 4'hF, 1'b1);
    issue(1'b0, 16'h0010, 32'h0, 4'h0, 1'b1);
    repeat (4) @(posedge clk); #1;

    // Reset with writes and a read still queued: all dropped, no strobe.
    mem_busy = 1'b1;
    issue(1'b1, 16'h0020, 32'hDEADBEEF, 4'hF, 1'b0);
    issue(1'b1, 16'h0021, 32'h55555555, 4'hF, 1'b0);
    issue(1'b1, 16'h0010, 32'h00000000, 4'hF, 1'b0);
    issue(1'b0, 16'h0020, 32'h0, 4'h0, 1'b0);
    rst_ = 1'b0;
    #1;
    check("rtr_mid_reset", 32'(out_rtr), 32'd0);
    check("idle_mid_reset", 32'(idle), 32'd1);
    repeat (2) @(posedge clk); #1;
    mem_busy = 1'b0;
    rst_ = 1'b1;
    @(posedge clk); #1;
    check("rtr_post_reset", 32'(out_rtr), 32'd1);
    check("xfc_post_reset", 32'(out_xfc), 32'd0);
    issue(1'b0, 16'h0020, 32'h0, 4'h0, 1'b1);
    issue(1'b0, 16'h0021, 32'h0, 4'h0, 1'b1);
    issue(1'b0, 16'h0010, 32'h0, 4'h0, 1'b1);

    // Drain with a bound.
    for (int i = 0; i < 50 && (sb.size() != 0 || !idle); i++) begin
      @(posedge clk); #1;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("idle_end", 32'(idle), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
